dmem_access_ctrl: RTL and testbench

- Sequencer/arbiter in front of the word-wide data memory. That memory has a combinational read with byte/half extraction and a word-only synchronous write.
- Shares the memory between two requesters: port 0 (core load/store unit) and port 1 (debug/loader).
- Turns sub-word stores into a read-modify-write pair, so partial stores never clobber neighbouring bytes.
- Flags misaligned accesses with an error response and performs no memory write for them.

---
 rtl/dmem_access_ctrl_pkg.sv | 26 ++
 rtl/dmem_access_ctrl_if.sv | 43 ++++
 rtl/dmem_access_ctrl_store_merge.sv | 27 ++
 rtl/dmem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Holds the sequencer states, the access size codes and the alignment rule.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // Size code 2'b11 falls into the word rule.
    function automatic logic misalign(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = addr_lo[0];
            default: misalign = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester and memory-side bundle of the data-memory access controller.
// The slave modport is the controller view; master is the requesters plus memory.
interface dmem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BIT_WIDTH  = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [BIT_WIDTH-1:0]  req_wdata0;
    logic [BIT_WIDTH-1:0]  req_wdata1;
    logic [1:0]            req_size0;
    logic [1:0]            req_size1;
    logic [1:0]            resp_valid;
    logic                  resp_err;
    logic [BIT_WIDTH-1:0]  resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [BIT_WIDTH-1:0]  mem_write_data;
    logic                  mem_write_en;
    logic                  mem_addr_byte;
    logic                  mem_addr_half;
    logic [BIT_WIDTH-1:0]  mem_read_data;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_size0, req_size1, mem_read_data,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_read_addr, mem_write_addr, mem_write_data, mem_write_en,
        output mem_addr_byte, mem_addr_half
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_size0, req_size1, mem_read_data,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_read_addr, mem_write_addr, mem_write_data, mem_write_en,
        input  mem_addr_byte, mem_addr_half
    );

endinterface

// File: rtl/dmem_access_ctrl_store_merge.sv
// Combinational lane merge for sub-word stores: drops the right-aligned store
// data into the addressed byte or half of the word just read from memory.
module dmem_store_merge
    import dmem_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] i_old,
    input  logic [BIT_WIDTH-1:0] i_wdata,
    input  logic [1:0]           i_addr_lo,
    input  logic [1:0]           i_size,
    output logic [BIT_WIDTH-1:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        case (i_size)
            SZ_BYTE: o_merged[8*i_addr_lo +: 8] = i_wdata[7:0];
            SZ_HALF: begin
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
                else              o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer in front of a word-write data memory.
// Sub-word stores run as read-modify-write; misaligned accesses answer with an error.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BIT_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  bus
);

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_last_grant;
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BIT_WIDTH-1:0]  r_wdata;
    logic [1:0]            r_size;
    logic [BIT_WIDTH-1:0]  r_merged;
    logic [1:0]            r_resp_valid;
    logic                  r_resp_err;
    logic [BIT_WIDTH-1:0]  r_resp_rdata;

    logic                  w_grant;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_is_word;
    logic                  w_load_merged;
    logic [1:0]            w_resp_valid;
    logic                  w_resp_err;
    logic [BIT_WIDTH-1:0]  w_resp_rdata;
    logic [BIT_WIDTH-1:0]  w_merged;

    // Contention goes to the port not granted last; a lone requester always wins.
    always_comb begin
        w_grant = ~r_last_grant;
        if (bus.req_valid == 2'b01)      w_grant = 1'b0;
        else if (bus.req_valid == 2'b10) w_grant = 1'b1;
    end

    assign w_accept      = (r_state == IDLE) && !rst && (bus.req_valid != 2'b00);
    assign bus.req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_misalign    = misalign(r_addr[1:0], r_size);
    assign w_is_word     = r_size[1];

    dmem_store_merge #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_store_merge (
        .i_old     (bus.mem_read_data),
        .i_wdata   (r_wdata),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .o_merged  (w_merged)
    );

    always_comb begin
        w_state_next  = r_state;
        w_resp_valid  = 2'b00;
        w_resp_err    = r_resp_err;
        w_resp_rdata  = r_resp_rdata;
        w_load_merged = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = ACCESS;
            end
            ACCESS: begin
                if (!w_misalign && r_we && !w_is_word) begin
                    w_state_next  = WRITE;
                    w_load_merged = 1'b1;
                end else begin
                    w_state_next         = IDLE;
                    w_resp_valid[r_port] = 1'b1;
                    w_resp_err           = w_misalign;
                    w_resp_rdata         = (!w_misalign && !r_we) ? bus.mem_read_data : '0;
                end
            end
            WRITE: begin
                w_state_next         = IDLE;
                w_resp_valid[r_port] = 1'b1;
                w_resp_err           = 1'b0;
                w_resp_rdata         = '0;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Memory controls decode from state so they fall together with an async reset.
    always_comb begin
        bus.mem_read_addr  = r_addr;
        bus.mem_write_addr = r_addr;
        bus.mem_write_data = (r_state == WRITE) ? r_merged : r_wdata;
        bus.mem_write_en   = ((r_state == ACCESS) && r_we && w_is_word && !w_misalign) ||
                             (r_state == WRITE);
        bus.mem_addr_byte  = (r_state == ACCESS) && !r_we && (r_size == SZ_BYTE);
        bus.mem_addr_half  = (r_state == ACCESS) && !r_we && (r_size == SZ_HALF);
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= 2'b00;
            r_merged     <= '0;
            r_resp_valid <= 2'b00;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
            r_resp_rdata <= w_resp_rdata;
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_port       <= w_grant;
                r_we         <= bus.req_we[w_grant];
                r_addr       <= w_grant ? bus.req_addr1  : bus.req_addr0;
                r_wdata      <= w_grant ? bus.req_wdata1 : bus.req_wdata0;
                r_size       <= w_grant ? bus.req_size1  : bus.req_size0;
            end
            if (w_load_merged) r_merged <= w_merged;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small byte-addressed memory model.
module tb_dmem_access_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   wr_cnt;
    logic [31:0] last_wr;
    logic [31:0] mem [0:63];
    logic [31:0] rd_word;

    dmem_access_ctrl_if #(.ADDR_WIDTH(32), .BIT_WIDTH(32)) bus ();

    dmem_access_ctrl #(
        .ADDR_WIDTH (32),
        .BIT_WIDTH  (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read with byte/half extraction, word write.
    always_comb begin
        rd_word = mem[bus.mem_read_addr[7:2]];
        if (bus.mem_addr_byte)
            bus.mem_read_data = {24'h0, rd_word[8*bus.mem_read_addr[1:0] +: 8]};
        else if (bus.mem_addr_half)
            bus.mem_read_data = {16'h0, bus.mem_read_addr[1] ? rd_word[31:16] : rd_word[15:0]};
        else
            bus.mem_read_data = rd_word;
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            mem[bus.mem_write_addr[7:2]] <= bus.mem_write_data;
            last_wr <= bus.mem_write_data;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size);
        bus.req_valid[port] = 1'b1;
        bus.req_we[port]    = we;
        if (port == 0) begin
            bus.req_addr0 = addr; bus.req_wdata0 = wdata; bus.req_size0 = size;
        end else begin
            bus.req_addr1 = addr; bus.req_wdata1 = wdata; bus.req_size1 = size;
        end
    endtask

    // One request end to end; latency counted in cycles from the accept cycle.
    task automatic issue(input string tag, input int port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input int exp_lat, input logic exp_err,
                         input logic chk_rd, input logic [31:0] exp_rd);
        int n;
        drive(port, we, addr, wdata, size);
        #1;
        n = 0;
        while (!bus.req_ready[port] && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " ready"}, {31'b0, bus.req_ready[port]}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid[port] = 1'b0;
        n = 1;
        do begin
            @(posedge clk); #1; n++;
        end while (bus.resp_valid == 2'b00 && n < 12);
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " resp_valid"}, {30'b0, bus.resp_valid}, (port == 0) ? 32'd1 : 32'd2);
        chk({tag, " resp_err"}, {31'b0, bus.resp_err}, {31'b0, exp_err});
        if (chk_rd) chk({tag, " rdata"}, bus.resp_rdata, exp_rd);
    endtask

    initial begin
        int n;
        int wr_before;
        logic [1:0] exp_port [0:3];
        vectors = 0; miscompares = 0; wr_cnt = 0; last_wr = '0;
        rst = 1'b1;
        bus.req_valid = 2'b11; bus.req_we = 2'b00;
        bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
        bus.req_size0 = 2'b10; bus.req_size1 = 2'b10;

        #12;
        chk("rst req_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("rst resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("rst resp_err", {31'b0, bus.resp_err}, 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst mem_write_en", {31'b0, bus.mem_write_en}, 32'd0);
        chk("rst byte/half", {30'b0, bus.mem_addr_byte, bus.mem_addr_half}, 32'd0);
        bus.req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;

        issue("sw p1 0x40", 1, 1'b1, 32'h40, 32'hDEADBEEF, 2'b10, 2, 1'b0, 1'b0, 32'h0);
        chk("mem after sw", mem[16], 32'hDEADBEEF);
        issue("lw 0x40", 0, 1'b0, 32'h40, 32'h0, 2'b10, 2, 1'b0, 1'b1, 32'hDEADBEEF);
        issue("lbu 0x43", 0, 1'b0, 32'h43, 32'h0, 2'b00, 2, 1'b0, 1'b1, 32'h000000DE);
        issue("lhu 0x42", 0, 1'b0, 32'h42, 32'h0, 2'b01, 2, 1'b0, 1'b1, 32'h0000DEAD);
        issue("sw 0x40", 0, 1'b1, 32'h40, 32'h11223344, 2'b10, 2, 1'b0, 1'b0, 32'h0);
        issue("sb 0x42", 0, 1'b1, 32'h42, 32'h000000AB, 2'b00, 3, 1'b0, 1'b0, 32'h0);
        chk("sb written word", last_wr, 32'h11AB3344);
        chk("mem after sb", mem[16], 32'h11AB3344);
        issue("sh p1 0x40", 1, 1'b1, 32'h40, 32'h00005566, 2'b01, 3, 1'b0, 1'b0, 32'h0);
        chk("mem after sh", mem[16], 32'h11AB5566);

        wr_before = wr_cnt;
        issue("lw 0x41", 0, 1'b0, 32'h41, 32'h0, 2'b10, 2, 1'b1, 1'b1, 32'h0);
        issue("sh 0x43", 0, 1'b1, 32'h43, 32'h00009999, 2'b01, 2, 1'b1, 1'b0, 32'h0);
        chk("misaligned no write", wr_cnt, wr_before);
        chk("mem after misaligned", mem[16], 32'h11AB5566);

        // Last grant was port 0, so port 1 wins the first contended round.
        exp_port[0] = 2'b10; exp_port[1] = 2'b01; exp_port[2] = 2'b10; exp_port[3] = 2'b01;
        drive(0, 1'b0, 32'h40, 32'h0, 2'b10);
        drive(1, 1'b0, 32'h42, 32'h0, 2'b01);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (bus.resp_valid == 2'b00 && n < 10);
            chk("rr spacing", n, 32'd2);
            chk("rr port", {30'b0, bus.resp_valid}, {30'b0, exp_port[k]});
            chk("rr rdata", bus.resp_rdata, exp_port[k][0] ? 32'h11AB5566 : 32'h000011AB);
        end
        bus.req_valid = 2'b00;

        drive(1, 1'b0, 32'h42, 32'h0, 2'b01);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (bus.resp_valid == 2'b00 && n < 10);
            chk("single spacing", n, 32'd2);
            chk("single port", {30'b0, bus.resp_valid}, 32'd2);
        end
        bus.req_valid = 2'b00;

        // Reset while the RMW sits in WRITE: the write must never land.
        wr_before = wr_cnt;
        drive(0, 1'b1, 32'h40, 32'h00000077, 2'b00);
        #1;
        chk("rmw ready", {30'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        chk("rmw write_en in WRITE", {31'b0, bus.mem_write_en}, 32'd1);
        chk("rmw merged data", bus.mem_write_data, 32'h11AB5577);
        #2 rst = 1'b1;
        #1;
        chk("rst drops write_en", {31'b0, bus.mem_write_en}, 32'd0);
        @(posedge clk); #1;
        chk("rst no resp", {30'b0, bus.resp_valid}, 32'd0);
        chk("rst mem unchanged", mem[16], 32'h11AB5566);
        chk("rst no write", wr_cnt, wr_before);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        issue("lw after rst", 0, 1'b0, 32'h40, 32'h0, 2'b10, 2, 1'b0, 1'b1, 32'h11AB5566);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
